// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot-time instruction-memory loader.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    ERROR
  } state_e;

  localparam int LANES           = 4;
  localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted stream bytes into a 32-bit word, first byte in the MSBs.
module byte_packer
  import mips_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_full
);

  localparam int CNT_W = $clog2(LANES);

  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]      word_q, word_d;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    if (clear) begin
      byte_cnt_d = '0;
      word_d     = '0;
    end else if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (byte_cnt_q == CNT_W'(i)) word_d[(LANES-1-i)*8 +: 8] = in_data;
      end
      byte_cnt_d = byte_cnt_q + 1'b1;
    end
  end

  // High on the edge where the last lane is being filled.
  assign word_full = accept && (byte_cnt_q == CNT_W'(LANES-1));
  assign word      = word_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// Boot loader: streams bytes into instruction memory word by word and holds
// the CPU in reset until the whole image is written.
module imem_load_ctrl
  import mips_boot_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int WORDS   = 256,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                 TIMER_W   = $clog2(TIMEOUT);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [ADDR_W-1:0]   addr_hold_q, addr_hold_d;
  logic [31:0]         wdata_hold_q, wdata_hold_d;
  logic                accept;
  logic                pk_clear;
  logic                pk_full;
  logic [31:0]         pk_word;

  assign accept = in_valid && in_ready;

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (pk_clear),
    .accept   (accept),
    .in_data  (in_data),
    .word     (pk_word),
    .word_full(pk_full)
  );

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      timer_q      <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      timer_q      <= timer_d;
      addr_hold_q  <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    timer_d      = timer_q;
    addr_hold_d  = addr_hold_q;
    wdata_hold_d = wdata_hold_q;
    pk_clear     = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d  = LOAD;
          addr_d   = '0;
          timer_d  = '0;
          pk_clear = 1'b1;
        end
      end
      LOAD: begin
        // An accept on the timeout edge still counts, so it is tested first.
        if (accept) begin
          timer_d = '0;
          if (pk_full) state_d = WRITE;
        end else if (timer_q == TIMER_MAX) begin
          state_d = ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WRITE: begin
        addr_hold_d  = addr_q;
        wdata_hold_d = pk_word;
        timer_d      = '0;
        if (addr_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address/data show the live word only while writing, else the last write.
  always_comb begin
    in_ready  = (state_q == LOAD);
    mem_we    = (state_q == WRITE);
    mem_addr  = (state_q == WRITE) ? addr_q  : addr_hold_q;
    mem_wdata = (state_q == WRITE) ? pk_word : wdata_hold_q;
    cpu_rst_n = (state_q == DONE);
    busy      = (state_q == LOAD) || (state_q == WRITE);
    done      = (state_q == DONE);
    err       = (state_q == ERROR);
  end

endmodule
